apb3_simple_bus_bridge: RTL

//  APB3 slave to simple cmd/rsp bus master bridge; sits directly upstream of the on-chip RAM.

---
 rtl/apb3_simple_bus_bridge_pkg.sv | 22 ++
 rtl/apb3_simple_bus_bridge_if.sv | 37 +++
 rtl/apb3_simple_bus_bridge.sv | 135 +++++++++++++
 3 files changed

// File: rtl/apb3_simple_bus_bridge_pkg.sv
// Shared definitions for the APB3 to simple cmd/rsp bus bridge:
// FSM state encoding, the fixed byte mask and the window check helper.
package apb3_simple_bus_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_WAIT = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  localparam logic [3:0] BUS_MASK_ALL = 4'hF;

  // Offset is already base-relative; an underflowed subtraction lands far outside the window.
  function automatic logic in_window(input logic [31:0] offset,
                                     input logic [1:0]  byte_lsb,
                                     input logic [32:0] win_bytes);
    return ({1'b0, offset} < win_bytes) && (byte_lsb == 2'b00);
  endfunction

endpackage

// File: rtl/apb3_simple_bus_bridge_if.sv
// Bus bundles used by the bridge: an APB3 slave-side port and a
// simple cmd/rsp master-side port towards the on-chip RAM.
interface apb3_if;
  import apb3_simple_bus_bridge_pkg::*;

  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  modport master (output paddr, psel, penable, pwrite, pwdata,
                  input  pready, prdata, pslverr);
  modport slave  (input  paddr, psel, penable, pwrite, pwdata,
                  output pready, prdata, pslverr);
endinterface

interface simple_bus_if;
  import apb3_simple_bus_bridge_pkg::*;

  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_address;
  logic [31:0] cmd_data;
  logic [3:0]  cmd_mask;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (output cmd_valid, cmd_write, cmd_address, cmd_data, cmd_mask,
                  input  cmd_ready, rsp_valid, rsp_data);
  modport slave  (input  cmd_valid, cmd_write, cmd_address, cmd_data, cmd_mask,
                  output cmd_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/apb3_simple_bus_bridge.sv
// APB3 slave to simple cmd/rsp bus master bridge guarding the RAM window.
// One cmd beat per APB access; reads wait (bounded) for the response.
module apb3_simple_bus_bridge
  import apb3_simple_bus_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned ADDR_DEPTH = 8192,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic         io_mainClk,
  input  logic         resetCtrl_systemReset,
  apb3_if.slave        apb,
  simple_bus_if.master bus
);

  localparam int unsigned     CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [32:0]     WIN_BYTES = 33'(ADDR_DEPTH) * 33'd4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic [31:0]       prdata_q, prdata_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              cmd_write_q, cmd_write_d;
  logic [31:0]       cmd_address_q, cmd_address_d;
  logic [31:0]       cmd_data_q, cmd_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cooldown_q, cooldown_d;

  logic        access;
  logic        addr_ok;
  logic        fire;
  logic        timed_out;
  logic [31:0] offset;

  // The cycle right after a completion still shows the finished access on the
  // APB pins; the cooldown flag keeps it from being issued a second time.
  assign access    = apb.psel && apb.penable && !cooldown_q;
  assign offset    = apb.paddr - BASE_ADDR;
  assign addr_ok   = in_window(offset, apb.paddr[1:0], WIN_BYTES);
  assign fire      = cmd_valid_q && bus.cmd_ready;
  assign timed_out = (cnt_q == CNT_LAST);

  always_ff @(posedge io_mainClk or posedge resetCtrl_systemReset) begin
    if (resetCtrl_systemReset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (access) state_d = addr_ok ? ST_CMD : ST_ERR;
      ST_CMD:  if (fire) state_d = cmd_write_q ? ST_DONE : ST_WAIT;
      ST_WAIT: begin
        if (bus.rsp_valid)  state_d = ST_DONE;
        else if (timed_out) state_d = ST_ERR;
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pready_d      = (state_d == ST_DONE) || (state_d == ST_ERR);
    pslverr_d     = (state_d == ST_ERR);
    cooldown_d    = (state_q == ST_DONE) || (state_q == ST_ERR);
    prdata_d      = prdata_q;
    cmd_valid_d   = cmd_valid_q;
    cmd_write_d   = cmd_write_q;
    cmd_address_d = cmd_address_q;
    cmd_data_d    = cmd_data_q;
    cnt_d         = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (access && addr_ok) begin
          cmd_valid_d   = 1'b1;
          cmd_write_d   = apb.pwrite;
          cmd_address_d = offset;
          cmd_data_d    = apb.pwdata;
        end
      end
      ST_CMD: begin
        if (fire) begin
          cmd_valid_d = 1'b0;
          cnt_d       = '0;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.rsp_valid) prdata_d = bus.rsp_data;
      end
      default: ;
    endcase
    if (state_d == ST_ERR) prdata_d = '0;
  end

  always_ff @(posedge io_mainClk or posedge resetCtrl_systemReset) begin
    if (resetCtrl_systemReset) begin
      pready_q      <= 1'b0;
      pslverr_q     <= 1'b0;
      prdata_q      <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_write_q   <= 1'b0;
      cmd_address_q <= '0;
      cmd_data_q    <= '0;
      cnt_q         <= '0;
      cooldown_q    <= 1'b0;
    end else begin
      pready_q      <= pready_d;
      pslverr_q     <= pslverr_d;
      prdata_q      <= prdata_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_write_q   <= cmd_write_d;
      cmd_address_q <= cmd_address_d;
      cmd_data_q    <= cmd_data_d;
      cnt_q         <= cnt_d;
      cooldown_q    <= cooldown_d;
    end
  end

  assign apb.pready      = pready_q;
  assign apb.pslverr     = pslverr_q;
  assign apb.prdata      = prdata_q;
  assign bus.cmd_valid   = cmd_valid_q;
  assign bus.cmd_write   = cmd_write_q;
  assign bus.cmd_address = cmd_address_q;
  assign bus.cmd_data    = cmd_data_q;
  assign bus.cmd_mask    = BUS_MASK_ALL;

endmodule
